// File: rtl/alu_writeback_stage_if.sv
// Handshake/bus bundle between the ALU, the writeback stage and the register-file write port.
// The master modport is the environment side; the slave modport is the stage.
interface alu_writeback_stage_if #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_res;
    logic              in_z;
    logic              in_c;
    logic              in_v;
    logic [2:0]        in_sel;
    logic [RD_W-1:0]   in_rd;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_res;
    logic [RD_W-1:0]   out_rd;
    logic              out_we;

    modport master (
        output in_valid, in_res, in_z, in_c, in_v, in_sel, in_rd, out_ready,
        input  in_ready, out_valid, out_res, out_rd, out_we
    );

    modport slave (
        input  in_valid, in_res, in_z, in_c, in_v, in_sel, in_rd, out_ready,
        output in_ready, out_valid, out_res, out_rd, out_we
    );
endinterface

// File: rtl/alu_writeback_stage.sv
// Registered ALU writeback stage: two-entry skid buffer feeding the register-file write port,
// plus committed status flags, sticky illegal-op error and a commit counter.
module alu_writeback_stage #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    alu_writeback_stage_if.slave  bus,
    input  logic                  err_clr,
    output logic                  flag_z,
    output logic                  flag_c,
    output logic                  flag_v,
    output logic                  err_op,
    output logic [CNT_W-1:0]      commit_cnt
);
    typedef struct packed {
        logic [DATA_W-1:0] res;
        logic              z;
        logic              c;
        logic              v;
        logic [2:0]        sel;
        logic [RD_W-1:0]   rd;
    } entry_t;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} occ_t;

    occ_t   state, state_next;
    entry_t head, skid, incoming;
    logic   in_ready, out_valid, push, pop, head_legal;

    always_comb begin
        incoming.res = bus.in_res;
        incoming.z   = bus.in_z;
        incoming.c   = bus.in_c;
        incoming.v   = bus.in_v;
        incoming.sel = bus.in_sel;
        incoming.rd  = bus.in_rd;
    end

    assign push       = bus.in_valid && in_ready;
    assign pop        = out_valid && bus.out_ready;
    assign head_legal = (head.sel <= 3'b100);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= EMPTY;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            EMPTY: if (push) state_next = ONE;
            ONE: begin
                if (push && !pop)      state_next = FULL;
                else if (pop && !push) state_next = EMPTY;
            end
            FULL:  if (pop) state_next = ONE;
            default: state_next = EMPTY;
        endcase
    end

    // in_ready depends on the registered state only, never on out_ready.
    always_comb begin
        out_valid     = (state != EMPTY);
        in_ready      = (state != FULL);
        bus.in_ready  = in_ready;
        bus.out_valid = out_valid;
        bus.out_res   = head.res;
        bus.out_rd    = head.rd;
        bus.out_we    = out_valid && head_legal;
    end

    // Head is the oldest entry; skid only holds the second one while the head is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= '0;
            skid <= '0;
        end else begin
            unique case (state)
                EMPTY: if (push) head <= incoming;
                ONE: begin
                    if (push && pop) head <= incoming;
                    else if (push)   skid <= incoming;
                end
                FULL:  if (pop) head <= skid;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_z     <= 1'b0;
            flag_c     <= 1'b0;
            flag_v     <= 1'b0;
            commit_cnt <= '0;
        end else if (pop) begin
            commit_cnt <= commit_cnt + 1'b1;
            unique case (head.sel)
                3'b000, 3'b001: begin
                    flag_z <= head.z;
                    flag_c <= head.c;
                    flag_v <= head.v;
                end
                3'b010, 3'b011, 3'b100: flag_z <= head.z;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                      err_op <= 1'b0;
        else if (pop && !head_legal)  err_op <= 1'b1;
        else if (err_clr)             err_op <= 1'b0;
    end
endmodule

// File: tb/tb_alu_writeback_stage.sv
// Directed self-checking bench for alu_writeback_stage; expected values are hand-computed.
module tb_alu_writeback_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        err_clr;
    logic        flag_z, flag_c, flag_v, err_op;
    logic [15:0] commit_cnt;
    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    alu_writeback_stage_if #(.DATA_W(32), .RD_W(5)) bus ();

    alu_writeback_stage #(.DATA_W(32), .RD_W(5), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave),
        .err_clr    (err_clr),
        .flag_z     (flag_z),
        .flag_c     (flag_c),
        .flag_v     (flag_v),
        .err_op     (err_op),
        .commit_cnt (commit_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic vld, input logic [31:0] res, input logic z, input logic c,
                         input logic v, input logic [2:0] sel, input logic [4:0] rd);
        bus.in_valid = vld;
        bus.in_res   = res;
        bus.in_z     = z;
        bus.in_c     = c;
        bus.in_v     = v;
        bus.in_sel   = sel;
        bus.in_rd    = rd;
    endtask

    task automatic chk_flags(input string tag, input logic z, input logic c, input logic v);
        chk({tag, "_z"}, {31'd0, flag_z}, {31'd0, z});
        chk({tag, "_c"}, {31'd0, flag_c}, {31'd0, c});
        chk({tag, "_v"}, {31'd0, flag_v}, {31'd0, v});
    endtask

    initial begin
        rst = 1'b1;
        err_clr = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0);
        tick(); tick();
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out_we", {31'd0, bus.out_we}, 32'd0);
        chk("rst_out_res", bus.out_res, 32'd0);
        chk("rst_out_rd", {27'd0, bus.out_rd}, 32'd0);
        chk_flags("rst", 1'b0, 1'b0, 1'b0);
        chk("rst_err", {31'd0, err_op}, 32'd0);
        chk("rst_cnt", {16'd0, commit_cnt}, 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // 1: single add, z=1 c=1 v=0
        bus.out_ready = 1'b1;
        drive(1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 3'd0, 5'd1);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0);
        chk("t1_out_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("t1_out_we", {31'd0, bus.out_we}, 32'd1);
        chk("t1_out_rd", {27'd0, bus.out_rd}, 32'd1);
        tick();
        chk_flags("t1", 1'b1, 1'b1, 1'b0);
        chk("t1_cnt", {16'd0, commit_cnt}, 32'd1);
        chk("t1_empty", {31'd0, bus.out_valid}, 32'd0);

        // 2: stalled sink, three back-to-back pushes
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h11, 1'b0, 1'b0, 1'b0, 3'd2, 5'd2);
        tick();
        drive(1'b1, 32'h22, 1'b1, 1'b0, 1'b0, 3'd3, 5'd3);
        tick();
        chk("t2_full_ready", {31'd0, bus.in_ready}, 32'd0);
        drive(1'b1, 32'h33, 1'b0, 1'b0, 1'b0, 3'd4, 5'd4);
        tick();
        chk("t2_3rd_blocked", {31'd0, bus.in_ready}, 32'd0);
        chk("t2_head_a_stable", bus.out_res, 32'h11);
        bus.out_ready = 1'b1;
        tick();
        chk("t2_head_b", bus.out_res, 32'h22);
        chk("t2_ready_after_pop", {31'd0, bus.in_ready}, 32'd1);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0);
        chk("t2_head_c", bus.out_res, 32'h33);
        chk("t2_head_c_rd", {27'd0, bus.out_rd}, 32'd4);
        tick();
        chk("t2_empty", {31'd0, bus.out_valid}, 32'd0);
        chk("t2_cnt", {16'd0, commit_cnt}, 32'd4);
        chk_flags("t2", 1'b0, 1'b1, 1'b0);

        // 3: sub sets c/v, following logical op updates z only
        drive(1'b1, 32'h5, 1'b0, 1'b1, 1'b1, 3'd1, 5'd5);
        tick();
        drive(1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 3'd2, 5'd6);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0);
        chk_flags("t3_after_sub", 1'b0, 1'b1, 1'b1);
        tick();
        chk_flags("t3_after_and", 1'b1, 1'b1, 1'b1);
        chk("t3_cnt", {16'd0, commit_cnt}, 32'd6);

        // 4: illegal op and sticky error
        bus.out_ready = 1'b0;
        drive(1'b1, 32'hDEAD, 1'b0, 1'b0, 1'b0, 3'b110, 5'd7);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0);
        chk("t4_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("t4_we", {31'd0, bus.out_we}, 32'd0);
        bus.out_ready = 1'b1;
        tick();
        chk("t4_err_set", {31'd0, err_op}, 32'd1);
        chk_flags("t4_hold", 1'b1, 1'b1, 1'b1);
        chk("t4_cnt", {16'd0, commit_cnt}, 32'd7);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t4_err_clr", {31'd0, err_op}, 32'd0);
        bus.out_ready = 1'b0;
        drive(1'b1, 32'hBEEF, 1'b0, 1'b0, 1'b0, 3'b111, 5'd8);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0);
        bus.out_ready = 1'b1;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t4_set_wins", {31'd0, err_op}, 32'd1);
        chk("t4_cnt2", {16'd0, commit_cnt}, 32'd8);

        // 5: occupancy 1, push+pop every cycle
        bus.out_ready = 1'b0;
        drive(1'b1, 32'd1000, 1'b0, 1'b0, 1'b0, 3'd2, 5'd9);
        tick();
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            drive(1'b1, 32'd1000 + 32'(i), 1'b0, 1'b0, 1'b0, 3'd2, 5'd9);
            chk("t5_in_ready", {31'd0, bus.in_ready}, 32'd1);
            chk("t5_order", bus.out_res, 32'd1000 + 32'(i) - 32'd1);
            tick();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0);
        chk("t5_head_last", bus.out_res, 32'd1100);
        chk("t5_cnt", {16'd0, commit_cnt}, 32'd108);
        tick();
        chk("t5_cnt_drained", {16'd0, commit_cnt}, 32'd109);
        chk("t5_err_still", {31'd0, err_op}, 32'd1);

        // 6: async reset with two entries buffered, then counter wrap
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h77, 1'b0, 1'b0, 1'b0, 3'd0, 5'd10);
        tick(); tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0);
        chk("t6_full", {31'd0, bus.in_ready}, 32'd0);
        #1 rst = 1'b1;
        #1;
        chk("t6_rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("t6_rst_err", {31'd0, err_op}, 32'd0);
        chk("t6_rst_cnt", {16'd0, commit_cnt}, 32'd0);
        chk_flags("t6_rst", 1'b0, 1'b0, 1'b0);
        #1 rst = 1'b0;
        tick();
        chk("t6_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("t6_no_stale", {31'd0, bus.out_valid}, 32'd0);
        bus.out_ready = 1'b1;
        drive(1'b1, 32'h1, 1'b0, 1'b0, 1'b0, 3'd0, 5'd1);
        tick();
        repeat (65535) tick();
        chk("t6_cnt_max", {16'd0, commit_cnt}, 32'h0000FFFF);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0);
        chk("t6_cnt_wrap", {16'd0, commit_cnt}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
